aes128_encrypt_iter: RTL and testbench
======================================

Name: aes128_encrypt_iter

Overview:
- Iterative AES-128 encryption core (FIPS-197), the forward-direction counterpart to the team's AES-128 decryption path.
- One round per clock, with on-the-fly key expansion.
- Single-block-in-flight engine with the same start/valid_in/done handshake as the decryption pipeline, so benches and wrappers can drive either direction identically.
- Ciphertext produced here must decrypt back to the plaintext through the existing decryption path.

Parameters:
- HOLD_OUTPUT, 1, 1 = data_out holds the last ciphertext until the next result; 0 = data_out reads zero whenever valid_out is low.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request to begin a block; qualified with valid_in
- valid_in  input  1  data_in/key_in valid this cycle
- data_in  input  128  plaintext; [127:120] = byte 0 (s0,0), column-major per FIPS-197
- key_in  input  128  cipher key, same byte order
- data_out  output  128  ciphertext, same byte order
- valid_out  output  1  one-cycle pulse: data_out holds a new ciphertext
- done  output  1  one-cycle pulse, coincident with valid_out
- busy  output  1  high while a block is in flight; inputs are ignored

Behaviour:
- Reset (rst=1 at a rising edge): FSM to IDLE; data_out=0, valid_out=0, done=0, busy=0; round counter, state and key registers cleared. A reset mid-operation aborts the block with no valid_out.
- FSM states: IDLE, RUN, OUT.
- IDLE: at an edge with start && valid_in, call it E0:
  - state <= data_in ^ key_in (initial AddRoundKey);
  - rkey <= key_in; rnd <= 1; busy <= 1; go to RUN.
  - start without valid_in, or valid_in without start: ignored.
- RUN: each edge E1..E10 performs round rnd:
  - next round key from rkey, with Rcon[rnd] = 01,02,04,08,10,20,40,80,1b,36;
  - SubBytes, ShiftRows, MixColumns (MixColumns omitted when rnd==10), then AddRoundKey with the new round key;
  - rnd increments.
  - At E10: data_out <= final state; valid_out <= 1; done <= 1; go to OUT.
- OUT: lasts exactly one cycle (valid_out=done=1, busy=1). The next edge clears valid_out and done, drops busy, and returns to IDLE.
- Latency: ciphertext is visible in the cycle after E10, i.e. 10 edges after the accepting edge. Throughput is one block per 12 cycles. The earliest next accept is the edge ending the OUT cycle plus one.
- While busy=1, start/valid_in are ignored entirely. A request held high across busy is accepted at the first IDLE edge.
- S-box: a 256-entry table or GF(2^8) inversion plus affine transform; either is acceptable if bit-exact. 16 state S-boxes plus 4 key S-boxes; no multicycle paths.
- xtime: shift left; XOR 0x1b if the MSB was set. All arithmetic is in GF(2^8), with no carries.
- HOLD_OUTPUT=0: data_out is forced to 0 in every cycle where valid_out=0.

Optional Feature:
- Macro: AES_ENC_LAST_KEY_OUT_EN
- Defined:
  - extra output port last_key_out [127:0] carries the round-10 key (the key the decryption path starts from);
  - it updates at E10 alongside data_out and follows HOLD_OUTPUT rules;
  - reset value is 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset, then key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> after 10 edges, valid_out=done=1 for one cycle, data_out=69c4e0d86a7b0430d8cdb78070b4c55a. With the macro defined, last_key_out=13111d7fe3944a17f307a78b4d2b30c5.
- Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> data_out=3925841d02dc09fbdc118597196a0b32; last_key_out=d014f9a8c9ee2589e13f0cc8b6630ca6 when enabled.
- All-zero key and pt -> 66e94bd4ef8a2c3b884cfa59ca342b2e. Then pulse a second request 3 cycles after accept (busy=1) -> ignored, exactly one valid_out, data_out unchanged afterwards (HOLD_OUTPUT=1).
- Assert rst at round 5 of a block -> valid_out never pulses for it; data_out=0, busy=0. A new request the cycle after reset completes correctly.
- Back-to-back: start/valid_in held high with 8 vectors fed as each is accepted -> 8 valid_out pulses, 12 cycles apart, each matching the reference model. Loopback through the decryption path returns the original plaintexts.
- HOLD_OUTPUT=0 build -> data_out=0 in every cycle except the valid_out cycle.

Source files
------------

// File: rtl/aes128_encrypt_iter.sv
// aes128_encrypt_iter: iterative AES-128 encryption core, one round per clock,
// with the round key expanded on the fly alongside the data path.
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a block (qualified by valid_in)
//   valid_in   data_in/key_in valid this cycle
//   data_in    128-bit plaintext, [127:120] = byte 0, column-major
//   key_in     128-bit cipher key, same byte order
//   data_out   128-bit ciphertext, same byte order
//   valid_out  one-cycle pulse when data_out carries a new ciphertext
//   done       one-cycle pulse, coincident with valid_out
//   busy       high while a block is in flight; inputs ignored
// Parameter HOLD_OUTPUT: 1 = data_out holds the last result, 0 = data_out is
// zero whenever valid_out is low.
// Optional macro AES_ENC_LAST_KEY_OUT_EN adds last_key_out (round-10 key).
module aes128_encrypt_iter #(
    parameter bit HOLD_OUTPUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         valid_in,
    input  logic [127:0] data_in,
    input  logic [127:0] key_in,
    output logic [127:0] data_out,
    output logic         valid_out,
    output logic         done,
    output logic         busy
`ifdef AES_ENC_LAST_KEY_OUT_EN
    ,
    output logic [127:0] last_key_out
`endif
);
    localparam int unsigned BLK_W = 128;
    localparam int unsigned RND_W = 4;
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(10);

    typedef enum logic [1:0] {IDLE, RUN, OUT} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [BLK_W-1:0] state_q, state_d;
    logic [BLK_W-1:0] rkey_q, rkey_d;
    logic [BLK_W-1:0] dout_q, dout_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [BLK_W-1:0] key_next, round_out;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [BLK_W-1:0] lkey_q, lkey_d;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (a^254, which maps 0 to 0) plus affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [RND_W-1:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // One step of the key schedule: RotWord, SubWord, Rcon, then the word chain
    function automatic logic [BLK_W-1:0] next_key(input logic [BLK_W-1:0] k,
                                                   input logic [7:0] rc);
        logic [31:0] t, n0, n1, n2, n3;
        t  = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // SubBytes, ShiftRows, optional MixColumns, AddRoundKey
    function automatic logic [BLK_W-1:0] enc_round(input logic [BLK_W-1:0] s,
                                                    input logic [BLK_W-1:0] k,
                                                    input logic last);
        logic [BLK_W-1:0] sb, sr, mc;
        logic [7:0] a0, a1, a2, a3;
        for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[127-32*c -: 8];
            a1 = sr[119-32*c -: 8];
            a2 = sr[111-32*c -: 8];
            a3 = sr[103-32*c -: 8];
            mc[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mc[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mc[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mc[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return (last ? sr : mc) ^ k;
    endfunction

    // Round datapath shared by all ten rounds
    always_comb begin
        key_next  = next_key(rkey_q, rcon(rnd_q));
        round_out = enc_round(state_q, key_next, rnd_q == LAST_RND);
    end

    // Next-state and output logic
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rkey_d  = rkey_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        dout_d  = HOLD_OUTPUT ? dout_q : '0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
        lkey_d  = HOLD_OUTPUT ? lkey_q : '0;
`endif
        case (fsm_q)
            IDLE: begin
                if (start && valid_in) begin
                    state_d = data_in ^ key_in;
                    rkey_d  = key_in;
                    rnd_d   = RND_W'(1);
                    busy_d  = 1'b1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                rkey_d  = key_next;
                rnd_d   = rnd_q + RND_W'(1);
                if (rnd_q == LAST_RND) begin
                    dout_d  = round_out;
                    valid_d = 1'b1;
`ifdef AES_ENC_LAST_KEY_OUT_EN
                    lkey_d  = key_next;
`endif
                    fsm_d   = OUT;
                end
            end
            OUT: begin
                busy_d = 1'b0;
                fsm_d  = IDLE;
            end
            default: begin
                busy_d = 1'b0;
                fsm_d  = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            dout_q  <= '0;
            rnd_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
            lkey_q  <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rkey_q  <= rkey_d;
            dout_q  <= dout_d;
            rnd_q   <= rnd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef AES_ENC_LAST_KEY_OUT_EN
            lkey_q  <= lkey_d;
`endif
        end
    end

    assign data_out  = dout_q;
    assign valid_out = valid_q;
    assign done      = valid_q;
    assign busy      = busy_q;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    assign last_key_out = lkey_q;
`endif

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Bench for aes128_encrypt_iter: a HOLD_OUTPUT=1 and a HOLD_OUTPUT=0 instance
// share inputs; results are checked against an array-based FIPS-197 model.
module tb_aes128_encrypt_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         start, valid_in;
    logic [127:0] data_in, key_in;
    logic [127:0] dout1, dout0;
    logic         val1, val0, done1, done0, busy1, busy0;
`ifdef AES_ENC_LAST_KEY_OUT_EN
    logic [127:0] lk1, lk0;
`endif

    int vecs = 0;
    int errs = 0;
    logic [7:0] sbox_t[256];
    logic [7:0] inv_t[256];

    always #5 clk = ~clk;

    aes128_encrypt_iter #(.HOLD_OUTPUT(1'b1)) u_hold (
        .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
        .data_in(data_in), .key_in(key_in), .data_out(dout1),
        .valid_out(val1), .done(done1), .busy(busy1)
`ifdef AES_ENC_LAST_KEY_OUT_EN
        , .last_key_out(lk1)
`endif
    );

    aes128_encrypt_iter #(.HOLD_OUTPUT(1'b0)) u_zero (
        .clk(clk), .rst(rst), .start(start), .valid_in(valid_in),
        .data_in(data_in), .key_in(key_in), .data_out(dout0),
        .valid_out(val0), .done(done0), .busy(busy0)
`ifdef AES_ENC_LAST_KEY_OUT_EN
        , .last_key_out(lk0)
`endif
    );

    // ---------------- reference model ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Generator walk: p steps by *3, q by /3, so q is always 1/p
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
        for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
    endtask

    function automatic logic [127:0] rkey(input logic [127:0] key, input int r);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]] ^ rc, sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [127:0] k, res;
        k = rkey(key, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[j+4*c] = s[j+4*((c+j)%4)];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c]   = gm(t[4*c],8'd2) ^ gm(t[4*c+1],8'd3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gm(t[4*c+1],8'd2) ^ gm(t[4*c+2],8'd3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gm(t[4*c+2],8'd2) ^ gm(t[4*c+3],8'd3);
                    s[4*c+3] = gm(t[4*c],8'd3) ^ t[4*c+1] ^ t[4*c+2] ^ gm(t[4*c+3],8'd2);
                end else begin
                    for (int j = 0; j < 4; j++) s[4*c+j] = t[4*c+j];
                end
            end
            k = rkey(key, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
        logic [7:0] s[16];
        logic [7:0] t[16];
        logic [127:0] k, res;
        k = rkey(key, 10);
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) t[j+4*((c+j)%4)] = s[j+4*c];
            k = rkey(key, r);
            for (int i = 0; i < 16; i++) s[i] = inv_t[t[i]] ^ k[127-8*i -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) t[j] = s[4*c+j];
                    s[4*c]   = gm(t[0],8'd14) ^ gm(t[1],8'd11) ^ gm(t[2],8'd13) ^ gm(t[3],8'd9);
                    s[4*c+1] = gm(t[0],8'd9) ^ gm(t[1],8'd14) ^ gm(t[2],8'd11) ^ gm(t[3],8'd13);
                    s[4*c+2] = gm(t[0],8'd13) ^ gm(t[1],8'd9) ^ gm(t[2],8'd14) ^ gm(t[3],8'd11);
                    s[4*c+3] = gm(t[0],8'd11) ^ gm(t[1],8'd13) ^ gm(t[2],8'd9) ^ gm(t[3],8'd14);
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [127:0] pt, input logic [127:0] key);
        start    = 1'b1;
        valid_in = 1'b1;
        data_in  = pt;
        key_in   = key;
        tick();
        start    = 1'b0;
        valid_in = 1'b0;
        data_in  = rnd128();
        key_in   = rnd128();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        repeat (40) begin
            tick();
            n++;
            if (val1) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        vecs++; if (dout1 !== 128'h0) begin errs++; $display("FAIL reset_dout1: got %h want 0", dout1); end
        vecs++; if (dout0 !== 128'h0) begin errs++; $display("FAIL reset_dout0: got %h want 0", dout0); end
        vecs++; if (val1 !== 1'b0 || val0 !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b%b want 00", val1, val0); end
        vecs++; if (done1 !== 1'b0 || done0 !== 1'b0) begin errs++; $display("FAIL reset_done: got %b%b want 00", done1, done0); end
        vecs++; if (busy1 !== 1'b0 || busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b%b want 00", busy1, busy0); end
`ifdef AES_ENC_LAST_KEY_OUT_EN
        vecs++; if (lk1 !== 128'h0) begin errs++; $display("FAIL reset_lastkey: got %h want 0", lk1); end
`endif
    endtask

    task automatic test_fips(input logic [127:0] key, input logic [127:0] pt, input logic [127:0] ct);
        int n;
        apply(pt, key);
        vecs++; if (busy1 !== 1'b1) begin errs++; $display("FAIL fips_busy_accept: got %b want 1", busy1); end
        wait_valid(n);
        vecs++; if (n !== 10) begin errs++; $display("FAIL fips_latency: got %0d want 10", n); end
        vecs++; if (dout1 !== ct) begin errs++; $display("FAIL fips_ct: got %h want %h", dout1, ct); end
        vecs++; if (dout0 !== ct || val0 !== 1'b1) begin errs++; $display("FAIL fips_ct_zero: got %h want %h", dout0, ct); end
        vecs++; if (done1 !== 1'b1 || busy1 !== 1'b1) begin errs++; $display("FAIL fips_out_flags: got done=%b busy=%b want 1 1", done1, busy1); end
`ifdef AES_ENC_LAST_KEY_OUT_EN
        vecs++; if (lk1 !== rkey(key, 10)) begin errs++; $display("FAIL fips_lastkey: got %h want %h", lk1, rkey(key, 10)); end
`endif
        tick();
        vecs++; if (val1 !== 1'b0 || done1 !== 1'b0 || busy1 !== 1'b0) begin errs++; $display("FAIL fips_after: got v=%b d=%b b=%b want 0 0 0", val1, done1, busy1); end
        vecs++; if (dout1 !== ct) begin errs++; $display("FAIL fips_hold: got %h want %h", dout1, ct); end
        vecs++; if (dout0 !== 128'h0) begin errs++; $display("FAIL fips_zero_after: got %h want 0", dout0); end
    endtask

    task automatic test_ignore_busy();
        logic [127:0] ct;
        int pulses, first;
        ct = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
        pulses = 0;
        first = -1;
        apply(128'h0, 128'h0);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            if (cyc == 3) begin
                start = 1'b1; valid_in = 1'b1; data_in = rnd128(); key_in = rnd128();
            end
            tick();
            if (cyc == 3) begin start = 1'b0; valid_in = 1'b0; end
            if (val1) begin pulses++; if (first < 0) first = cyc; end
        end
        vecs++; if (pulses !== 1) begin errs++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
        vecs++; if (first !== 10) begin errs++; $display("FAIL busy_latency: got %0d want 10", first); end
        vecs++; if (dout1 !== ct) begin errs++; $display("FAIL busy_ct: got %h want %h", dout1, ct); end
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL busy_idle: got %b want 0", busy1); end
    endtask

    task automatic test_spurious();
        int pulses;
        pulses = 0;
        start = 1'b1; valid_in = 1'b0; data_in = rnd128(); key_in = rnd128();
        tick();
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL spur_start_only: got busy %b want 0", busy1); end
        start = 1'b0; valid_in = 1'b1;
        tick();
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL spur_valid_only: got busy %b want 0", busy1); end
        valid_in = 1'b0;
        repeat (14) begin tick(); if (val1) pulses++; end
        vecs++; if (pulses !== 0) begin errs++; $display("FAIL spur_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] pt, key;
        int n, pulses;
        pulses = 0;
        apply(rnd128(), rnd128());
        repeat (5) begin tick(); if (val1) pulses++; end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++; if (pulses !== 0 || val1 !== 1'b0) begin errs++; $display("FAIL rstmid_valid: got %0d pulses v=%b want 0", pulses, val1); end
        vecs++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin errs++; $display("FAIL rstmid_flags: got busy=%b done=%b want 0 0", busy1, done1); end
        vecs++; if (dout1 !== 128'h0 || dout0 !== 128'h0) begin errs++; $display("FAIL rstmid_dout: got %h want 0", dout1); end
        pt = rnd128();
        key = rnd128();
        apply(pt, key);
        wait_valid(n);
        vecs++; if (n !== 10) begin errs++; $display("FAIL rstmid_latency: got %0d want 10", n); end
        vecs++; if (dout1 !== aes_enc(pt, key)) begin errs++; $display("FAIL rstmid_ct: got %h want %h", dout1, aes_enc(pt, key)); end
        tick();
        vecs++; if (val1 !== 1'b0) begin errs++; $display("FAIL rstmid_after: got %b want 0", val1); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] pts[8];
        logic [127:0] keys[8];
        int cnt;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin pts[i] = rnd128(); keys[i] = rnd128(); end
        start = 1'b1; valid_in = 1'b1; data_in = pts[0]; key_in = keys[0];
        for (int e = 0; e < 110; e++) begin
            tick();
            if (e % 12 == 0 && e / 12 < 8) begin
                if (e / 12 + 1 < 8) begin
                    data_in = pts[e/12+1]; key_in = keys[e/12+1];
                end else begin
                    start = 1'b0; valid_in = 1'b0;
                end
            end
            if (val1) begin
                if (cnt < 8) begin
                    vecs++; if (e !== 10 + 12 * cnt) begin errs++; $display("FAIL b2b_timing%0d: got edge %0d want %0d", cnt, e, 10 + 12 * cnt); end
                    vecs++; if (dout1 !== aes_enc(pts[cnt], keys[cnt])) begin errs++; $display("FAIL b2b_ct%0d: got %h want %h", cnt, dout1, aes_enc(pts[cnt], keys[cnt])); end
                    vecs++; if (aes_dec(dout1, keys[cnt]) !== pts[cnt]) begin errs++; $display("FAIL b2b_loop%0d: got %h want %h", cnt, aes_dec(dout1, keys[cnt]), pts[cnt]); end
                end
                cnt++;
            end else if (dout0 !== 128'h0) begin
                vecs++; errs++; $display("FAIL b2b_zero: got %h want 0 at edge %0d", dout0, e);
            end
        end
        vecs++; if (cnt !== 8) begin errs++; $display("FAIL b2b_count: got %0d want 8", cnt); end
        vecs++; if (busy1 !== 1'b0) begin errs++; $display("FAIL b2b_idle: got %b want 0", busy1); end
    endtask

    task automatic test_hold0();
        logic [127:0] pt, key;
        int cnt;
        for (int it = 0; it < 3; it++) begin
            pt = rnd128();
            key = rnd128();
            cnt = 0;
            apply(pt, key);
            for (int cyc = 1; cyc <= 13; cyc++) begin
                tick();
                if (val0) begin
                    cnt++;
                    vecs++; if (cyc !== 10 || dout0 !== aes_enc(pt, key)) begin errs++; $display("FAIL hold0_ct: got %h at %0d want %h at 10", dout0, cyc, aes_enc(pt, key)); end
                end else begin
                    vecs++; if (dout0 !== 128'h0) begin errs++; $display("FAIL hold0_zero: got %h want 0 at %0d", dout0, cyc); end
                end
            end
            vecs++; if (cnt !== 1) begin errs++; $display("FAIL hold0_pulses: got %0d want 1", cnt); end
            vecs++; if (dout1 !== aes_enc(pt, key)) begin errs++; $display("FAIL hold1_hold: got %h want %h", dout1, aes_enc(pt, key)); end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        key_in = '0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_fips(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        test_fips(128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32);
        test_ignore_busy();
        test_spurious();
        test_reset_mid();
        test_back_to_back();
        test_hold0();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
